pll_reconfig_ctrl: RTL and testbench
====================================

PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: cycles a synchronized setting must hold before it is acted on.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum cycles to wait for PLL lock.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16: minimum cycles after the start write before lock is accepted.
REQ-004 SHALL have port clk, input, 1: single clock, used as the PLL management clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-006 SHALL have port model, input, 1: 0=Professional, 1=Business; asynchronous to clk.
REQ-007 SHALL have port ntsc, input, 1: 0=PAL, 1=NTSC; asynchronous to clk.
REQ-008 SHALL have port pll_locked, input, 1: PLL lock indicator; asynchronous to clk.
REQ-009 SHALL have port cfg_waitrequest, input, 1: reconfig slave stall.
REQ-010 SHALL have port cfg_write, output, 1: reconfig write strobe.
REQ-011 SHALL have port cfg_address, output, 6: reconfig register address.
REQ-012 SHALL have port cfg_data, output, 32: reconfig write data.
REQ-013 SHALL have port busy, output, 1: sequence in progress.
REQ-014 SHALL have port core_reset, output, 1: holds the machine core in reset while the clock is invalid.
REQ-015 SHALL have port cfg_error, output, 1: sticky flag, set on lock timeout.

Function
REQ-016 SHALL pass model, ntsc and pll_locked through 2-FF synchronizers before any use.
REQ-017 SHALL treat a synchronized {model,ntsc} as stable once unchanged for STABLE_CYCLES consecutive cycles.
REQ-018 SHALL hold programmed registers prog_model and prog_ntsc; a sequence SHALL start from IDLE when the stable model differs from prog_model.
REQ-019 SHALL also start a sequence when the stable ntsc differs from prog_ntsc and the stable model is 0.
REQ-020 When the stable model is 1 and only ntsc differs, SHALL update prog_ntsc without running a sequence.
REQ-021 SHALL latch prog_model and prog_ntsc from the stable values at the IDLE->WR_MODE transition; later input changes SHALL be re-evaluated only after return to IDLE.
REQ-022 SHALL use states IDLE -> WR_MODE -> WR_C -> WR_FRAC -> WR_START -> WAIT_LOCK -> IDLE.
REQ-023 WR_MODE SHALL write address 0, data 0.
REQ-024 WR_C SHALL write address 5, data 0x80808 if prog_model=1, else 0x80909.
REQ-025 WR_FRAC SHALL write address 7, data 2233382994 if prog_model=1, else 3357876127 if prog_ntsc=1, else 1503512573.
REQ-026 WR_START SHALL write address 2, data 0.
REQ-027 Write handshake: SHALL assert cfg_write with cfg_address and cfg_data, and hold all three constant until a rising edge samples cfg_waitrequest=0.
REQ-028 That edge SHALL complete the write; cfg_write SHALL be 0 for at least 1 cycle before the next write.
REQ-029 Each write state SHALL issue exactly one transfer, then advance.
REQ-030 WAIT_LOCK SHALL count cycles from 0.
REQ-031 WAIT_LOCK SHALL exit to IDLE when synchronized pll_locked=1 and count>=SETTLE_CYCLES.
REQ-032 WAIT_LOCK SHALL exit to IDLE and set cfg_error when count reaches LOCK_TIMEOUT without lock.
REQ-033 busy SHALL be 1 in every state except IDLE.
REQ-034 core_reset SHALL be registered and equal 1 while busy=1 or synchronized pll_locked=0.
REQ-035 cfg_write SHALL be 0 in IDLE and WAIT_LOCK.
REQ-036 cfg_error SHALL clear only on reset.
REQ-037 A change to the inputs during a sequence SHALL NOT abort it; it SHALL be handled per REQ-018..021 on return to IDLE.

Reset
REQ-038 On reset: state=IDLE, prog_model=0, prog_ntsc=0, stability counters=0, synchronizers=0.
REQ-039 On reset: cfg_write=0, cfg_address=0, cfg_data=0, busy=0, cfg_error=0, core_reset=1.
REQ-040 Reset asserted mid-sequence SHALL abort immediately; any partially issued write SHALL be dropped with cfg_write=0.
REQ-041 After reset release, SHALL evaluate inputs against prog={0,0} per REQ-018..020.

Verification
REQ-042 Scenario: reset, model=1, waitrequest=0, lock returns after 20 cycles -> writes (0,0), (5,0x80808), (7,2233382994), (2,0) in order; busy falls; core_reset falls 1 cycle later.
REQ-043 Scenario: model=0, ntsc toggled 0->1 and held -> a single write sequence containing (7,3357876127).
REQ-044 Scenario: model=1, ntsc toggled -> no cfg_write; prog_ntsc=1.
REQ-045 Scenario: glitch of ntsc lasting 2 cycles -> no sequence.
REQ-046 Scenario: cfg_waitrequest held 1 for 10 cycles on the address-5 write -> cfg_write, cfg_address and cfg_data stable for all 11 cycles; one transfer only.
REQ-047 Scenario: pll_locked held 0 -> cfg_error=1 after LOCK_TIMEOUT; state IDLE; core_reset stays 1; reset mid-WR_FRAC -> cfg_write=0 at once.

Source files
------------

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration sequencer: watches the synchronized model/ntsc straps and, when
// the selected video clock changes, reprograms the PLL through its reconfig slave.
module pll_reconfig_ctrl #(
  parameter int STABLE_CYCLES = 4,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        model,
  input  logic        ntsc,
  input  logic        pll_locked,
  input  logic        cfg_waitrequest,
  output logic        cfg_write,
  output logic [5:0]  cfg_address,
  output logic [31:0] cfg_data,
  output logic        busy,
  output logic        core_reset,
  output logic        cfg_error
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int LOCK_MAX = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
  localparam int LOCK_W = $clog2(LOCK_MAX + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WR_MODE   = 3'd1;
  localparam logic [2:0] WR_C      = 3'd2;
  localparam logic [2:0] WR_FRAC   = 3'd3;
  localparam logic [2:0] WR_START  = 3'd4;
  localparam logic [2:0] WAIT_LOCK = 3'd5;

  logic [2:0]        sync1;
  logic [2:0]        sync2;
  logic              model_s;
  logic              ntsc_s;
  logic              locked_s;
  logic [1:0]        hold_val;
  logic [STAB_W-1:0] stab_cnt;
  logic              is_stable;
  logic              stable_model;
  logic              stable_ntsc;
  logic [2:0]        state;
  logic              prog_model;
  logic              prog_ntsc;
  logic [LOCK_W-1:0] lock_cnt;
  logic [5:0]        wr_addr;
  logic [31:0]       wr_data;
  logic [2:0]        wr_next;

  // NOTE: every register uses <= so all flops sample pre-edge values, as hardware does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {model, ntsc, pll_locked};
      sync2 <= sync1;
    end
  end

  assign model_s  = sync2[2];
  assign ntsc_s   = sync2[1];
  assign locked_s = sync2[0];

  // Any change restarts the hold count; the straps are trusted only once it saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_val <= '0;
      stab_cnt <= '0;
    end else if ({model_s, ntsc_s} != hold_val) begin
      hold_val <= {model_s, ntsc_s};
      stab_cnt <= '0;
    end else if (stab_cnt != STAB_W'(STABLE_CYCLES)) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  assign is_stable    = (stab_cnt == STAB_W'(STABLE_CYCLES));
  assign stable_model = hold_val[1];
  assign stable_ntsc  = hold_val[0];

  // NOTE: combinational decode assigns defaults first so no latch is inferred.
  always_comb begin
    wr_addr = 6'd0;
    wr_data = 32'd0;
    wr_next = IDLE;
    case (state)
      WR_MODE: begin
        wr_addr = 6'd0;
        wr_data = 32'd0;
        wr_next = WR_C;
      end
      WR_C: begin
        wr_addr = 6'd5;
        wr_data = prog_model ? 32'h0008_0808 : 32'h0008_0909;
        wr_next = WR_FRAC;
      end
      WR_FRAC: begin
        wr_addr = 6'd7;
        wr_data = prog_model ? 32'd2233382994 :
                  prog_ntsc  ? 32'd3357876127 : 32'd1503512573;
        wr_next = WR_START;
      end
      WR_START: begin
        wr_addr = 6'd2;
        wr_data = 32'd0;
        wr_next = WAIT_LOCK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prog_model  <= 1'b0;
      prog_ntsc   <= 1'b0;
      cfg_write   <= 1'b0;
      cfg_address <= '0;
      cfg_data    <= '0;
      lock_cnt    <= '0;
      cfg_error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_stable) begin
            if ((stable_model != prog_model) ||
                (!stable_model && (stable_ntsc != prog_ntsc))) begin
              prog_model <= stable_model;
              prog_ntsc  <= stable_ntsc;
              state      <= WR_MODE;
            end else if (stable_ntsc != prog_ntsc) begin
              // Business machines share one clock for PAL and NTSC.
              prog_ntsc <= stable_ntsc;
            end
          end
        end
        WR_MODE, WR_C, WR_FRAC, WR_START: begin
          // Entry always sees cfg_write low, which yields the idle gap between transfers.
          if (!cfg_write) begin
            cfg_write   <= 1'b1;
            cfg_address <= wr_addr;
            cfg_data    <= wr_data;
          end else if (!cfg_waitrequest) begin
            cfg_write <= 1'b0;
            state     <= wr_next;
            lock_cnt  <= '0;
          end
        end
        WAIT_LOCK: begin
          if (locked_s && (lock_cnt >= LOCK_W'(SETTLE_CYCLES))) begin
            state <= IDLE;
          end else if (lock_cnt >= LOCK_W'(LOCK_TIMEOUT)) begin
            state     <= IDLE;
            cfg_error <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) core_reset <= 1'b1;
    else       core_reset <= busy || !locked_s;
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: strap changes, glitches, stalls, lock timeout
// and mid-sequence reset, with a bus monitor recording every completed transfer.
module tb_pll_reconfig_ctrl;

  localparam int LOCK_TO = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        model;
  logic        ntsc;
  logic        pll_locked;
  logic        cfg_waitrequest;
  logic        cfg_write;
  logic [5:0]  cfg_address;
  logic [31:0] cfg_data;
  logic        busy;
  logic        core_reset;
  logic        cfg_error;

  pll_reconfig_ctrl #(
    .STABLE_CYCLES(4),
    .LOCK_TIMEOUT (LOCK_TO),
    .SETTLE_CYCLES(16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .model          (model),
    .ntsc           (ntsc),
    .pll_locked     (pll_locked),
    .cfg_waitrequest(cfg_waitrequest),
    .cfg_write      (cfg_write),
    .cfg_address    (cfg_address),
    .cfg_data       (cfg_data),
    .busy           (busy),
    .core_reset     (core_reset),
    .cfg_error      (cfg_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: completed transfers, write gaps and stability while stalled.
  logic [37:0] wr_q[$];
  int          gap_err  = 0;
  int          hold_err = 0;
  logic        last_done  = 1'b0;
  logic        last_stall = 1'b0;
  logic [37:0] last_req   = '0;

  always @(posedge clk) begin
    if (cfg_write && !cfg_waitrequest) wr_q.push_back({cfg_address, cfg_data});
    if (cfg_write && last_done) gap_err++;
    if (last_stall && !(cfg_write && {cfg_address, cfg_data} == last_req)) hold_err++;
    last_done  = cfg_write && !cfg_waitrequest;
    last_stall = cfg_write && cfg_waitrequest;
    last_req   = {cfg_address, cfg_data};
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    @(negedge clk);
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy) check({tag, "_idle_timeout"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_xfers(input string tag, input int n, input int budget);
    int k = 0;
    while (wr_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (wr_q.size() < n) check({tag, "_xfer_timeout"}, 64'(wr_q.size()), 64'(n));
  endtask

  task automatic wait_addr(input string tag, input logic [5:0] addr, input int budget);
    int k = 0;
    while (!(cfg_write && cfg_address == addr) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!(cfg_write && cfg_address == addr)) check({tag, "_addr_timeout"}, 64'(cfg_address), 64'(addr));
  endtask

  task automatic check_seq(input string tag, input logic [31:0] c_data, input logic [31:0] frac);
    logic [37:0] exp_q[4];
    exp_q[0] = {6'd0, 32'd0};
    exp_q[1] = {6'd5, c_data};
    exp_q[2] = {6'd7, frac};
    exp_q[3] = {6'd2, 32'd0};
    check({tag, "_count"}, 64'(wr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < wr_q.size()) check($sformatf("%s_w%0d", tag, i), 64'(wr_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    int held;
    reset = 1'b1;
    model = 1'b0;
    ntsc = 1'b0;
    pll_locked = 1'b1;
    cfg_waitrequest = 1'b0;
    cycles(3);
    check("rst_write", 64'(cfg_write), 64'd0);
    check("rst_addr", 64'(cfg_address), 64'd0);
    check("rst_data", 64'(cfg_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_error", 64'(cfg_error), 64'd0);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    reset = 1'b0;

    // Straps equal the reset programming: nothing happens, core comes out of reset.
    cycles(12);
    check("idle_no_write", 64'(wr_q.size()), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_core_reset", 64'(core_reset), 64'd0);

    // Two-cycle ntsc glitch is filtered.
    ntsc = 1'b1;
    cycles(2);
    ntsc = 1'b0;
    cycles(15);
    check("glitch_no_write", 64'(wr_q.size()), 64'd0);
    check("glitch_busy", 64'(busy), 64'd0);

    // Professional, PAL -> NTSC: one full sequence with the NTSC fraction.
    ntsc = 1'b1;
    wait_xfers("ntsc", 1, 100);
    wait_idle("ntsc", 200);
    check_seq("ntsc", 32'h0008_0909, 32'd3357876127);
    cycles(10);
    check("ntsc_single_seq", 64'(wr_q.size()), 64'd4);
    wr_q.delete();

    // Switch to Business; lock comes back 20 cycles after the last write.
    pll_locked = 1'b0;
    model = 1'b1;
    wait_xfers("biz", 4, 200);
    cycles(20);
    pll_locked = 1'b1;
    wait_idle("biz", 200);
    check("biz_core_reset_lag", 64'(core_reset), 64'd1);
    @(negedge clk);
    check("biz_core_reset_fall", 64'(core_reset), 64'd0);
    check_seq("biz", 32'h0008_0808, 32'd2233382994);
    check("biz_error", 64'(cfg_error), 64'd0);
    wr_q.delete();

    // Business: ntsc toggles only update the programmed register.
    ntsc = 1'b0;
    cycles(15);
    check("biz_ntsc0_prog", 64'(dut.prog_ntsc), 64'd0);
    ntsc = 1'b1;
    cycles(15);
    check("biz_ntsc1_prog", 64'(dut.prog_ntsc), 64'd1);
    check("biz_ntsc_no_write", 64'(wr_q.size()), 64'd0);
    check("biz_ntsc_busy", 64'(busy), 64'd0);

    // Back to Professional with a 10-cycle stall on the address-5 write.
    model = 1'b0;
    wait_addr("stall", 6'd5, 100);
    held = 0;
    if (cfg_write && cfg_address == 6'd5 && cfg_data == 32'h0008_0909) held++;
    cfg_waitrequest = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cfg_write && cfg_address == 6'd5 && cfg_data == 32'h0008_0909) held++;
    end
    cfg_waitrequest = 1'b0;
    check("stall_held_cycles", 64'(held), 64'd11);
    wait_idle("stall", 200);
    check_seq("stall", 32'h0008_0909, 32'd3357876127);
    wr_q.delete();

    // Lock never returns: timeout sets the sticky error.
    pll_locked = 1'b0;
    model = 1'b1;
    wait_xfers("tmo", 4, 100);
    wait_idle("tmo", LOCK_TO + 100);
    check("tmo_error", 64'(cfg_error), 64'd1);
    check("tmo_busy", 64'(busy), 64'd0);
    cycles(10);
    check("tmo_core_reset", 64'(core_reset), 64'd1);
    check("tmo_error_sticky", 64'(cfg_error), 64'd1);
    check("tmo_no_restart", 64'(wr_q.size()), 64'd4);
    wr_q.delete();

    // Reset while the fraction write is on the bus drops it at once.
    model = 1'b0;
    wait_addr("abort", 6'd7, 100);
    reset = 1'b1;
    #1;
    check("abort_write", 64'(cfg_write), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_error_clr", 64'(cfg_error), 64'd0);
    pll_locked = 1'b1;
    cycles(2);
    wr_q.delete();
    reset = 1'b0;

    // After release the straps {0,1} differ from prog {0,0}: a fresh sequence runs.
    wait_xfers("rearm", 1, 100);
    wait_idle("rearm", 200);
    check_seq("rearm", 32'h0008_0909, 32'd3357876127);

    check("gap_violations", 64'(gap_err), 64'd0);
    check("hold_violations", 64'(hold_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1);
  end

endmodule
